// File: rtl/attn_seq_pkg.sv
// attn_seq_pkg: shared definitions for the attention-core instruction sequencer.
//   state_e     4-bit sequencer state codes (also driven on the debug state port)
//   sfp_mode_e  SFP command codes carried in the top field of the instruction word
//   F_*         bit indices of the single-bit flags in inst[7:0]
//   *_lsb()     field offsets inside the instruction word as a function of ADDR_W
package attn_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_Q_WRITE    = 4'd1,
        ST_K_WRITE    = 4'd2,
        ST_K_LOAD     = 4'd3,
        ST_EXEC       = 4'd4,
        ST_ROW_WAIT   = 4'd5,
        ST_SFP_ACCUM  = 4'd6,
        ST_SFP_HOLD   = 4'd7,
        ST_SFP_DIV    = 4'd8,
        ST_WRITE_PMEM = 4'd9,
        ST_DONE       = 4'd10,
        ST_READBACK   = 4'd11
    } state_e;

    typedef enum logic [1:0] {
        SFP_OFF   = 2'b00,
        SFP_ACCUM = 2'b01,
        SFP_HOLD  = 2'b10,
        SFP_DIV   = 2'b11
    } sfp_mode_e;

    localparam int unsigned F_PMEM_WR = 0;
    localparam int unsigned F_PMEM_RD = 1;
    localparam int unsigned F_KMEM_WR = 2;
    localparam int unsigned F_KMEM_RD = 3;
    localparam int unsigned F_QMEM_WR = 4;
    localparam int unsigned F_QMEM_RD = 5;
    localparam int unsigned F_LOAD    = 6;
    localparam int unsigned F_EXECUTE = 7;

    localparam int unsigned PMEM_LSB = 8;

    function automatic int unsigned qk_lsb(input int unsigned aw);
        return 8 + aw;
    endfunction

    function automatic int unsigned ofifo_bit(input int unsigned aw);
        return 8 + 2 * aw;
    endfunction

    function automatic int unsigned sfp_lsb(input int unsigned aw);
        return 9 + 2 * aw;
    endfunction

endpackage

// File: rtl/attn_seq_cnt.sv
// attn_seq_cnt: ADDR_W-bit up-counter used for the phase address and row index.
//   clk, reset  clock and synchronous active-high reset
//   clr_i       synchronous clear (wins over en_i)
//   en_i        increment
//   limit_i     runtime terminal value
//   nxt_o       value the counter will hold after this edge
//   tc_o        current value equals limit_i
module attn_seq_cnt #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] limit_i,
    output logic [ADDR_W-1:0] nxt_o,
    output logic              tc_o
);

    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign nxt_o = cnt_d;
    assign tc_o  = (cnt_q == limit_i);

endmodule

// File: rtl/attn_seq_ctrl.sv
// attn_seq_ctrl: drives one attention core through a full pass
// (Q/K fill, K load, execute, per-row softmax and PMEM write).
//   clk, reset     clock and synchronous active-high reset
//   start          begin a pass (sampled only in IDLE)
//   ld_done        K load into the MAC columns finished
//   ofifo_valid    OFIFO holds a complete row
//   sfp_ready      SFP can accept a command
//   int_fifo_full  partner core's partial sum present
//   inst           registered instruction word {sfp_mode, ofifo_rd, qk_add, pmem_add, flags[7:0]}
//   state          current state code (debug)
//   busy           state != IDLE
//   done           one-cycle pulse at the end of a pass
// Optional feature: define ATTN_SEQ_PMEM_READBACK_EN to add a PMEM read-back
// burst (READBACK state) after the last row is written.
module attn_seq_ctrl
    import attn_seq_pkg::*;
#(
    parameter  int unsigned ADDR_W  = 4,
    parameter  int unsigned Q_DEPTH = 16,
    parameter  int unsigned K_DEPTH = 8,
    localparam int unsigned INST_W  = 2 * ADDR_W + 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ld_done,
    input  logic              ofifo_valid,
    input  logic              sfp_ready,
    input  logic              int_fifo_full,
    output logic [INST_W-1:0] inst,
    output logic [3:0]        state,
    output logic              busy,
    output logic              done
);

    localparam int unsigned QK_LSB    = qk_lsb(ADDR_W);
    localparam int unsigned OFIFO_BIT = ofifo_bit(ADDR_W);
    localparam int unsigned SFP_LSB   = sfp_lsb(ADDR_W);
    localparam logic [ADDR_W-1:0] Q_LAST = ADDR_W'(Q_DEPTH - 1);
    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(K_DEPTH - 1);

    state_e              state_q, state_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic                burst_q, burst_d;   // K_LOAD kmem_rd burst finished
    logic                busy_q, done_q;

    logic                pc_clr, pc_en, pc_tc;
    logic [ADDR_W-1:0]   pc_limit, pc_nxt;
    logic                rc_clr, rc_en, rc_tc;
    logic [ADDR_W-1:0]   rc_nxt;

    assign pc_limit = (state_q == ST_K_WRITE || state_q == ST_K_LOAD) ? K_LAST : Q_LAST;

    attn_seq_cnt #(.ADDR_W(ADDR_W)) u_phase_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (pc_clr),
        .en_i    (pc_en),
        .limit_i (pc_limit),
        .nxt_o   (pc_nxt),
        .tc_o    (pc_tc)
    );

    attn_seq_cnt #(.ADDR_W(ADDR_W)) u_row_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (rc_clr),
        .en_i    (rc_en),
        .limit_i (Q_LAST),
        .nxt_o   (rc_nxt),
        .tc_o    (rc_tc)
    );

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        pc_clr  = 1'b0;
        pc_en   = 1'b0;
        rc_clr  = 1'b0;
        rc_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pc_clr = 1'b1;
                rc_clr = 1'b1;
                if (start) state_d = ST_Q_WRITE;
            end
            ST_Q_WRITE: begin
                if (pc_tc) begin state_d = ST_K_WRITE; pc_clr = 1'b1; end
                else pc_en = 1'b1;
            end
            ST_K_WRITE: begin
                burst_d = 1'b0;
                if (pc_tc) begin state_d = ST_K_LOAD; pc_clr = 1'b1; end
                else pc_en = 1'b1;
            end
            ST_K_LOAD: begin
                // The last kmem_rd cycle already counts as burst complete, so
                // ld_done seen there exits with no tail cycle.
                if (!burst_q) begin
                    if (pc_tc) begin burst_d = 1'b1; pc_clr = 1'b1; end
                    else pc_en = 1'b1;
                end
                if (ld_done && (burst_q || pc_tc)) begin
                    state_d = ST_EXEC;
                    burst_d = 1'b0;
                    pc_clr  = 1'b1;
                end
            end
            ST_EXEC: begin
                if (pc_tc) begin
                    state_d = ST_ROW_WAIT;
                    pc_clr  = 1'b1;
                    rc_clr  = 1'b1;
                end else pc_en = 1'b1;
            end
            ST_ROW_WAIT:  if (ofifo_valid && sfp_ready) state_d = ST_SFP_ACCUM;
            ST_SFP_ACCUM: state_d = ST_SFP_HOLD;
            ST_SFP_HOLD:  if (int_fifo_full && sfp_ready) state_d = ST_SFP_DIV;
            ST_SFP_DIV:   state_d = ST_WRITE_PMEM;
            ST_WRITE_PMEM: begin
                if (rc_tc) begin
`ifdef ATTN_SEQ_PMEM_READBACK_EN
                    state_d = ST_READBACK;
                    pc_clr  = 1'b1;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    rc_en   = 1'b1;
                    state_d = ST_ROW_WAIT;
                end
            end
`ifdef ATTN_SEQ_PMEM_READBACK_EN
            ST_READBACK: begin
                if (pc_tc) begin state_d = ST_DONE; pc_clr = 1'b1; end
                else pc_en = 1'b1;
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The instruction is built from the next state and next counter values so
    // the registered word lines up with the first cycle of each state.
    always_comb begin
        inst_d = '0;
        case (state_d)
            ST_Q_WRITE: begin
                inst_d[F_QMEM_WR] = 1'b1;
                inst_d[QK_LSB +: ADDR_W] = pc_nxt;
            end
            ST_K_WRITE: begin
                inst_d[F_KMEM_WR] = 1'b1;
                inst_d[QK_LSB +: ADDR_W] = pc_nxt;
            end
            ST_K_LOAD: begin
                inst_d[F_LOAD] = 1'b1;
                if (!burst_d) begin
                    inst_d[F_KMEM_RD] = 1'b1;
                    inst_d[QK_LSB +: ADDR_W] = pc_nxt;
                end
            end
            ST_EXEC: begin
                inst_d[F_EXECUTE] = 1'b1;
                inst_d[F_QMEM_RD] = 1'b1;
                inst_d[QK_LSB +: ADDR_W] = pc_nxt;
            end
            ST_ROW_WAIT: inst_d[PMEM_LSB +: ADDR_W] = rc_nxt;
            ST_SFP_ACCUM: begin
                inst_d[SFP_LSB +: 2]  = SFP_ACCUM;
                inst_d[OFIFO_BIT]     = 1'b1;
            end
            ST_SFP_HOLD: inst_d[SFP_LSB +: 2] = SFP_HOLD;
            ST_SFP_DIV:  inst_d[SFP_LSB +: 2] = SFP_DIV;
            ST_WRITE_PMEM: begin
                inst_d[F_PMEM_WR] = 1'b1;
                inst_d[PMEM_LSB +: ADDR_W] = rc_nxt;
            end
`ifdef ATTN_SEQ_PMEM_READBACK_EN
            ST_READBACK: begin
                inst_d[F_PMEM_RD] = 1'b1;
                inst_d[PMEM_LSB +: ADDR_W] = pc_nxt;
            end
`endif
            default: inst_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            inst_q  <= '0;
            burst_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            burst_q <= burst_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign inst  = inst_q;
    assign state = state_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_attn_seq_ctrl.sv
// tb_attn_seq_ctrl: self-checking bench for attn_seq_ctrl.
// A procedural script walks the expected pass (phase by phase, row by row)
// while driving randomized handshake inputs, and compares every cycle's
// inst/state/busy/done against the word it builds from the field layout.
module tb_attn_seq_ctrl;

    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned Q_DEPTH = 16;
    localparam int unsigned K_DEPTH = 8;
    localparam int unsigned INST_W  = 2 * ADDR_W + 11;

    localparam logic [7:0] F_EXEC = 8'h80;
    localparam logic [7:0] F_LOAD = 8'h40;
    localparam logic [7:0] F_QRD  = 8'h20;
    localparam logic [7:0] F_QWR  = 8'h10;
    localparam logic [7:0] F_KRD  = 8'h08;
    localparam logic [7:0] F_KWR  = 8'h04;
    localparam logic [7:0] F_PRD  = 8'h02;
    localparam logic [7:0] F_PWR  = 8'h01;

    logic              clk = 1'b0;
    logic              reset, start, ld_done, ofifo_valid, sfp_ready, int_fifo_full;
    logic [INST_W-1:0] inst;
    logic [3:0]        state;
    logic              busy, done;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    attn_seq_ctrl #(
        .ADDR_W  (ADDR_W),
        .Q_DEPTH (Q_DEPTH),
        .K_DEPTH (K_DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .ld_done       (ld_done),
        .ofifo_valid   (ofifo_valid),
        .sfp_ready     (sfp_ready),
        .int_fifo_full (int_fifo_full),
        .inst          (inst),
        .state         (state),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [INST_W-1:0] mk(input logic [1:0] sfp, input logic ofr,
                                             input int unsigned qk, input int unsigned pm,
                                             input logic [7:0] fl);
        logic [ADDR_W-1:0] qa, pa;
        qa = qk[ADDR_W-1:0];
        pa = pm[ADDR_W-1:0];
        return {sfp, ofr, qa, pa, fl};
    endfunction

    function automatic logic rnd(input int mode);
        if (mode == 0) return 1'b1;
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cycle(input string tag, input logic [INST_W-1:0] ei,
                                input int unsigned es, input logic eb, input logic ed);
        check({tag, ".inst"},  inst,  ei);
        check({tag, ".state"}, state, es);
        check({tag, ".busy"},  busy,  eb);
        check({tag, ".done"},  done,  ed);
    endtask

    // mode 0: every handshake input held 1; mode 1: random handshakes;
    // mode 2: random, but row 3 sees int_fifo_full low for 20 HOLD cycles.
    task automatic run_pass(input int mode, input bit abort_exec);
        bit          go;
        int unsigned w;
        expect_cycle("idle", '0, 0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        for (int unsigned a = 0; a < Q_DEPTH; a++) begin
            start = 1'($urandom_range(0, 1));
            expect_cycle("q_write", mk(2'b00, 1'b0, a, 0, F_QWR), 1, 1'b1, 1'b0);
            tick();
        end
        for (int unsigned a = 0; a < K_DEPTH; a++) begin
            expect_cycle("k_write", mk(2'b00, 1'b0, a, 0, F_KWR), 2, 1'b1, 1'b0);
            tick();
        end
        go = 1'b0;
        for (int unsigned a = 0; a < K_DEPTH; a++) begin
            expect_cycle("k_load_rd", mk(2'b00, 1'b0, a, 0, F_LOAD | F_KRD), 3, 1'b1, 1'b0);
            ld_done = rnd(mode);
            if (a == K_DEPTH - 1 && ld_done) go = 1'b1;
            tick();
        end
        w = 0;
        while (!go) begin
            expect_cycle("k_load_tail", mk(2'b00, 1'b0, 0, 0, F_LOAD), 3, 1'b1, 1'b0);
            w++;
            ld_done = (w > 30) ? 1'b1 : rnd(mode);
            go = ld_done;
            tick();
        end
        ld_done = 1'b0;
        for (int unsigned a = 0; a < Q_DEPTH; a++) begin
            expect_cycle("exec", mk(2'b00, 1'b0, a, 0, F_EXEC | F_QRD), 4, 1'b1, 1'b0);
            if (abort_exec && a == 7) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                expect_cycle("reset_exec", '0, 0, 1'b0, 1'b0);
                start = 1'b0;
                tick();
                return;
            end
            tick();
        end
        for (int unsigned r = 0; r < Q_DEPTH; r++) begin
            w = 0;
            do begin
                expect_cycle("row_wait", mk(2'b00, 1'b0, 0, r, 8'h00), 5, 1'b1, 1'b0);
                ofifo_valid = rnd(mode);
                sfp_ready   = rnd(mode);
                if (w > 30) begin ofifo_valid = 1'b1; sfp_ready = 1'b1; end
                go = ofifo_valid && sfp_ready;
                w++;
                tick();
            end while (!go);
            expect_cycle("sfp_accum", mk(2'b01, 1'b1, 0, 0, 8'h00), 6, 1'b1, 1'b0);
            ofifo_valid = rnd(mode);
            int_fifo_full = rnd(mode);
            tick();
            w = 0;
            do begin
                expect_cycle("sfp_hold", mk(2'b10, 1'b0, 0, 0, 8'h00), 7, 1'b1, 1'b0);
                if (mode == 2 && r == 3) begin
                    int_fifo_full = (w >= 20);
                    sfp_ready     = 1'b1;
                end else begin
                    int_fifo_full = rnd(mode);
                    sfp_ready     = rnd(mode);
                    if (w > 30) begin int_fifo_full = 1'b1; sfp_ready = 1'b1; end
                end
                go = int_fifo_full && sfp_ready;
                w++;
                tick();
            end while (!go);
            int_fifo_full = rnd(mode);
            expect_cycle("sfp_div", mk(2'b11, 1'b0, 0, 0, 8'h00), 8, 1'b1, 1'b0);
            tick();
            expect_cycle("write_pmem", mk(2'b00, 1'b0, 0, r, F_PWR), 9, 1'b1, 1'b0);
            tick();
        end
`ifdef ATTN_SEQ_PMEM_READBACK_EN
        for (int unsigned a = 0; a < Q_DEPTH; a++) begin
            expect_cycle("readback", mk(2'b00, 1'b0, 0, a, F_PRD), 11, 1'b1, 1'b0);
            tick();
        end
`endif
        expect_cycle("done", '0, 10, 1'b1, 1'b1);
        start = 1'b0;
        tick();
        expect_cycle("idle_after", '0, 0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ld_done = 1'b0;
        ofifo_valid = 1'b0;
        sfp_ready = 1'b0;
        int_fifo_full = 1'b0;
        tick();
        tick();
        expect_cycle("reset", '0, 0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        run_pass(0, 1'b0);
        run_pass(1, 1'b0);
        run_pass(2, 1'b0);
        run_pass(1, 1'b1);
        run_pass(0, 1'b0);
        run_pass(1, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
